// File: rtl/led_pattern_sequencer.sv
// ============================================================================
// Module   : led_pattern_sequencer
// Purpose  : Avalon-MM slave that plays a table of timed LED patterns.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_pattern_sequencer #(
    parameter int STEPS = 8,
    parameter int DUR_W = 8,
    parameter int PRE_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  out_port,
    output logic        irq
);

    localparam int IDX_W = $clog2(STEPS);

    localparam logic [2:0] C_ADDR_CTRL   = 3'd0;
    localparam logic [2:0] C_ADDR_STATUS = 3'd1;
    localparam logic [2:0] C_ADDR_LAST   = 3'd2;
    localparam logic [2:0] C_ADDR_PRE    = 3'd3;
    localparam logic [2:0] C_ADDR_STEP   = 3'd4;
    localparam logic [2:0] C_ADDR_MANUAL = 3'd5;

    localparam logic [IDX_W-1:0] C_IDX_ONE = 1;
    localparam logic [DUR_W-1:0] C_DUR_ONE = 1;
    localparam logic [PRE_W-1:0] C_PRE_ONE = 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t           state_q;
    logic             run_q;
    logic             loop_q;
    logic             irq_en_q;
    logic             done_q;
    logic [IDX_W-1:0] last_q;
    logic [PRE_W-1:0] pre_q;
    logic [7:0]       manual_q;
    logic [7:0]       pat_q [STEPS];
    logic [DUR_W-1:0] dur_q [STEPS];
    logic [IDX_W-1:0] step_q;
    logic [DUR_W-1:0] dcnt_q;
    logic [PRE_W-1:0] pcnt_q;
    logic [7:0]       out_q;

    logic             wr_stb;
    logic             ctrl_wr;
    logic             busy;
    logic [DUR_W-1:0] dcnt_d;
    logic             unused_wdata;

    assign wr_stb       = chipselect & ~write_n;
    assign ctrl_wr      = wr_stb && (address == C_ADDR_CTRL);
    assign busy         = (state_q != S_IDLE);
    assign out_port     = out_q;
    assign irq          = done_q & irq_en_q;
    assign unused_wdata = ^writedata[31:16+IDX_W];

    // Zero duration behaves like one tick.
    assign dcnt_d = (dur_q[step_q] == '0) ? '0 : dur_q[step_q] - C_DUR_ONE;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loop_q   <= 1'b0;
            irq_en_q <= 1'b0;
            last_q   <= '0;
            pre_q    <= '0;
            manual_q <= '0;
            for (int i = 0; i < STEPS; i++) begin
                pat_q[i] <= '0;
                dur_q[i] <= '0;
            end
        end else if (wr_stb) begin
            case (address)
                C_ADDR_CTRL: begin
                    loop_q   <= writedata[1];
                    irq_en_q <= writedata[2];
                end
                C_ADDR_LAST:   last_q   <= writedata[IDX_W-1:0];
                C_ADDR_PRE:    pre_q    <= writedata[PRE_W-1:0];
                C_ADDR_MANUAL: manual_q <= writedata[7:0];
                C_ADDR_STEP: begin
                    pat_q[writedata[16 +: IDX_W]] <= writedata[7:0];
                    dur_q[writedata[16 +: IDX_W]] <= writedata[8 +: DUR_W];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= '0;
            dcnt_q  <= '0;
            pcnt_q  <= '0;
            out_q   <= '0;
        end else begin
            if (wr_stb && (address == C_ADDR_STATUS) && writedata[1])
                done_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    out_q  <= manual_q;
                    pcnt_q <= '0;
                end
                S_LOAD: begin
                    out_q   <= pat_q[step_q];
                    dcnt_q  <= dcnt_d;
                    pcnt_q  <= pre_q;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (pcnt_q == '0) begin
                        pcnt_q <= pre_q;
                        if (dcnt_q != '0) begin
                            dcnt_q <= dcnt_q - C_DUR_ONE;
                        end else if (step_q != last_q) begin
                            step_q  <= step_q + C_IDX_ONE;
                            state_q <= S_LOAD;
                        end else if (loop_q) begin
                            step_q  <= '0;
                            state_q <= S_LOAD;
                        end else begin
                            done_q  <= 1'b1;
                            run_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end else begin
                        pcnt_q <= pcnt_q - C_PRE_ONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // A CTRL write overrides whatever the sequence did this cycle.
            if (ctrl_wr) begin
                if (writedata[0]) begin
                    run_q   <= 1'b1;
                    step_q  <= '0;
                    done_q  <= 1'b0;
                    state_q <= S_LOAD;
                end else begin
                    run_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            C_ADDR_CTRL:   readdata[2:0] = {irq_en_q, loop_q, run_q};
            C_ADDR_STATUS: begin
                readdata[0]          = busy;
                readdata[1]          = done_q;
                readdata[8 +: IDX_W] = step_q;
            end
            C_ADDR_LAST:   readdata[IDX_W-1:0] = last_q;
            C_ADDR_PRE:    readdata[PRE_W-1:0] = pre_q;
            C_ADDR_MANUAL: readdata[7:0]       = manual_q;
            default:       readdata = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_sequencer.sv
// ============================================================================
// Module   : tb_led_pattern_sequencer
// Purpose  : Scoreboard bench for led_pattern_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_led_pattern_sequencer;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;
    logic        irq;

    led_pattern_sequencer #(.STEPS(8), .DUR_W(8), .PRE_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t q[$];
    logic chk_valid;
    int   total;
    int   bad;

    // kind 0: out_port, 1: irq, 2: readdata
    always @(negedge clk) begin
        chk_t        c;
        logic [31:0] act;
        if (chk_valid) begin
            while (q.size() > 0) begin
                c = q.pop_front();
                case (c.kind)
                    0:       act = {24'b0, out_port};
                    1:       act = {31'b0, irq};
                    default: act = readdata;
                endcase
                total++;
                if (act !== c.exp) begin
                    bad++;
                    $display("FAIL %s: got %h want %h", c.name, act, c.exp);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        chk_valid  = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cyc();
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
    endtask

    task automatic push(input int k, input logic [31:0] e, input string n);
        chk_t c;
        c.kind = k;
        c.exp  = e;
        c.name = n;
        q.push_back(c);
        chk_valid = 1'b1;
    endtask

    task automatic exp_out(input logic [7:0] e, input string n);
        push(0, {24'b0, e}, n);
    endtask

    task automatic exp_irq(input logic e, input string n);
        push(1, {31'b0, e}, n);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string n);
        address = a;
        push(2, e, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total      = 0;
        bad        = 0;
        chk_valid  = 1'b0;
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        repeat (3) cyc();
        reset_n = 1'b1;

        // Reset state
        for (int a = 0; a < 8; a++) begin
            cyc();
            rd(a[2:0], 32'h0, "reset_read");
        end
        cyc();
        exp_out(8'h00, "reset_out");
        exp_irq(1'b0, "reset_irq");

        // Manual value in idle
        wr(3'd5, 32'hA5);
        cyc();
        cyc();
        exp_out(8'hA5, "manual_out");
        rd(3'd5, 32'hA5, "manual_rd");

        // Single pass: 0x01 for 3 clocks, 0x02 for 4 clocks
        wr(3'd4, 32'h0000_0201);
        wr(3'd4, 32'h0001_0302);
        wr(3'd2, 32'h1);
        wr(3'd3, 32'h0);
        wr(3'd0, 32'h5);
        cyc();
        exp_out(8'hA5, "once_load_cycle");
        rd(3'd1, 32'h001, "once_busy");
        for (int k = 1; k <= 7; k++) begin
            cyc();
            exp_out((k <= 3) ? 8'h01 : 8'h02, "once_seq");
            if (k == 5) rd(3'd1, 32'h101, "once_step1");
            if (k == 7) begin
                rd(3'd1, 32'h102, "once_done_status");
                exp_irq(1'b1, "once_irq");
            end
        end
        cyc();
        exp_out(8'hA5, "once_revert");
        rd(3'd0, 32'h4, "once_run_cleared");
        wr(3'd1, 32'h2);
        cyc();
        exp_irq(1'b0, "w1c_irq");
        rd(3'd1, 32'h100, "w1c_status");

        // Loop with PRESCALE=3: period 9 + 13 clocks
        wr(3'd3, 32'h3);
        wr(3'd0, 32'h3);
        for (int k = 0; k <= 66; k++) begin
            cyc();
            if (k == 0) exp_out(8'hA5, "loop_load_cycle");
            else        exp_out((((k - 1) % 22) < 9) ? 8'h01 : 8'h02, "loop_seq");
            if (k == 15) rd(3'd1, 32'h101, "loop_step1");
            if (k == 30) rd(3'd1, 32'h001, "loop_step0");
            if (k == 66) rd(3'd1, 32'h001, "loop_no_done");
        end
        wr(3'd0, 32'h0);
        cyc();
        rd(3'd1, 32'h0, "stop_status");
        exp_out(8'h01, "stop_hold_out");
        cyc();
        exp_out(8'hA5, "stop_revert");
        rd(3'd0, 32'h0, "stop_ctrl");

        // Duration 0: one LOAD plus one HOLD cycle
        wr(3'd4, 32'h0000_0055);
        wr(3'd2, 32'h0);
        wr(3'd3, 32'h0);
        wr(3'd0, 32'h1);
        cyc();
        cyc();
        exp_out(8'h55, "dur0_out");
        rd(3'd1, 32'h001, "dur0_busy");
        cyc();
        rd(3'd1, 32'h002, "dur0_done");
        exp_irq(1'b0, "dur0_irq_masked");
        cyc();
        exp_out(8'hA5, "dur0_revert");

        // Restart while busy at step 1
        wr(3'd4, 32'h0000_0201);
        wr(3'd2, 32'h1);
        wr(3'd0, 32'h1);
        repeat (5) cyc();
        exp_out(8'h02, "pre_restart_out");
        wr(3'd0, 32'h1);
        exp_out(8'h02, "restart_wr_out");
        cyc();
        rd(3'd1, 32'h001, "restart_step");
        exp_out(8'h02, "restart_load_out");
        cyc();
        exp_out(8'h01, "restart_pat");

        // Asynchronous reset in HOLD at step 1
        repeat (3) cyc();
        rd(3'd1, 32'h101, "pre_rst_step");
        cyc();
        #2;
        reset_n = 1'b0;
        #1;
        exp_out(8'h00, "async_rst_out");
        rd(3'd1, 32'h0, "async_rst_busy");
        cyc();
        reset_n = 1'b1;
        cyc();
        rd(3'd1, 32'h0, "post_rst_status");
        cyc();
        rd(3'd3, 32'h0, "post_rst_pre");
        cyc();
        rd(3'd2, 32'h0, "post_rst_last");

        cyc();
        cyc();
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
